genius_button_conditioner: RTL and testbench

- Parametrised N-channel input conditioner for the Genius game's colour buttons.
- Per channel: synchroniser, debouncer and rising-edge detector.
- Arbitrates presses across channels, rejects chorded presses, and encodes the winning button index into a colour code.
- Sits between the raw push-button pins and the game controller; delivers each press through a one-entry valid/ready buffer.

---
 rtl/genius_button_conditioner.sv | 107 ++++++++++
 tb/tb_genius_button_conditioner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/genius_button_conditioner.sv
// Genius colour-button conditioner: per-channel synchroniser, debouncer and rise detector,
// chord rejection, and a one-entry valid/ready press buffer carrying the button index.
module genius_button_conditioner #(
    parameter int N_BUTTONS       = 4,
    parameter int CODE_W          = $clog2(N_BUTTONS),
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic                 press_valid,
    output logic [CODE_W-1:0]    press_code,
    input  logic                 press_ready,
    output logic                 multi_err,
    output logic                 overflow
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (2 ** CODE_W < N_BUTTONS) begin : g_code_w_check
        $error("CODE_W is too narrow to encode every button index");
    end
    if (N_BUTTONS < 2) begin : g_n_buttons_check
        $error("N_BUTTONS must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [N_BUTTONS-1:0] sync_q1;
    logic [N_BUTTONS-1:0] sync_q2;
    logic [N_BUTTONS-1:0] btn_level_q;
    logic [CNT_W-1:0]     db_cnt [N_BUTTONS];

    logic [N_BUTTONS-1:0] rise;
    logic [CODE_W-1:0]    rise_idx;
    logic                 one_rise;
    logic                 accept;
    logic                 chord;

    // The counter only runs while the synchronised level disagrees with the debounced one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1     <= '0;
            sync_q2     <= '0;
            btn_level   <= '0;
            btn_level_q <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_q1     <= btn_raw;
            sync_q2     <= sync_q1;
            btn_level_q <= btn_level;
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (sync_q2[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    btn_level[i] <= ~btn_level[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rise     = btn_level & ~btn_level_q;
        rise_idx = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (rise[i]) begin
                rise_idx = CODE_W'(i);
            end
        end
        one_rise = (rise != '0) && ((rise & (rise - N_BUTTONS'(1))) == '0);
        // A lone rise is only a press if no other button is already held down.
        accept   = enable && one_rise && ((btn_level & ~rise) == '0);
        chord    = enable && (rise != '0) && !accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_valid <= 1'b0;
            press_code  <= '0;
            multi_err   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            multi_err <= chord;
            overflow  <= 1'b0;
            if (!enable) begin
                press_valid <= 1'b0;
            end else if (accept) begin
                if (!press_valid || press_ready) begin
                    press_valid <= 1'b1;
                    press_code  <= rise_idx;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (press_ready) begin
                press_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_genius_button_conditioner.sv
// Self-checking bench for genius_button_conditioner: directed scenarios plus random button
// activity compared every cycle against a behavioural model.
module tb_genius_button_conditioner;
    localparam int NB = 4;
    localparam int CW = 2;
    localparam int D  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          press_ready = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic          press_valid;
    logic [CW-1:0] press_code;
    logic          multi_err;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    genius_button_conditioner #(
        .N_BUTTONS      (NB),
        .CODE_W         (CW),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .press_valid(press_valid),
        .press_code (press_code),
        .press_ready(press_ready),
        .multi_err  (multi_err),
        .overflow   (overflow)
    );

    // Behavioural model: a level changes once the last D synchronised samples since the
    // previous change all disagree with it; a press is a single new level with nothing else held.
    logic [NB-1:0] m_s1, m_s2, m_level, m_level_q, m_rise, m_lvl_next;
    logic          m_valid, m_multi, m_ovf, m_acc, m_consume, m_all_diff;
    logic [CW-1:0] m_code;
    int            m_idx;
    bit            m_hist [NB][$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_level_q = '0;
            m_valid = 1'b0; m_multi = 1'b0; m_ovf = 1'b0; m_code = '0;
            for (int i = 0; i < NB; i++) m_hist[i].delete();
        end else begin
            m_rise    = m_level & ~m_level_q;
            m_acc     = enable && ($countones(m_rise) == 1) && ($countones(m_level) == 1);
            m_multi   = enable && (m_rise != '0) && !m_acc;
            m_idx     = 0;
            for (int i = 0; i < NB; i++) if (m_rise[i]) m_idx = i;
            m_consume = m_valid && press_ready;
            m_ovf     = 1'b0;
            if (!enable) m_valid = 1'b0;
            else if (m_acc) begin
                if (!m_valid || m_consume) begin
                    m_valid = 1'b1;
                    m_code  = CW'(m_idx);
                end else m_ovf = 1'b1;
            end else if (m_consume) m_valid = 1'b0;

            m_lvl_next = m_level;
            for (int i = 0; i < NB; i++) begin
                m_hist[i].push_back(m_s2[i]);
                if (m_hist[i].size() > D) void'(m_hist[i].pop_front());
                if (m_hist[i].size() == D) begin
                    m_all_diff = 1'b1;
                    for (int j = 0; j < D; j++) if (m_hist[i][j] == m_level[i]) m_all_diff = 1'b0;
                    if (m_all_diff) begin
                        m_lvl_next[i] = ~m_level[i];
                        m_hist[i].delete();
                    end
                end
            end
            m_level_q = m_level;
            m_level   = m_lvl_next;
            m_s2      = m_s1;
            m_s1      = btn_raw;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("model_level", 32'(btn_level), 32'(m_level));
        chk("model_valid", 32'(press_valid), 32'(m_valid));
        chk("model_code", 32'(press_code), 32'(m_code));
        chk("model_multi", 32'(multi_err), 32'(m_multi));
        chk("model_ovf", 32'(overflow), 32'(m_ovf));
    endtask

    // Clean 3-sample press of one button, then release; ready pulses on step ready_at if nonzero.
    task automatic press_btn(input int idx, input int ready_at,
                             output int n_ovf, output int n_multi, output int n_idle);
        n_ovf = 0; n_multi = 0; n_idle = 0;
        btn_raw = NB'(1) << idx;
        for (int j = 1; j <= 10; j++) begin
            step();
            if (j == 3) btn_raw = '0;
            if (j == ready_at) press_ready = 1'b1;
            else if (j == ready_at + 1) press_ready = 1'b0;
            n_ovf   += int'(overflow);
            n_multi += int'(multi_err);
            n_idle  += int'(!press_valid);
        end
    endtask

    int nm, nv, nl, n_ovf, n_multi, n_idle;

    initial begin
        // reset with every button held: chord straight out of reset
        rst_n = 1'b0; btn_raw = 4'b1111; enable = 1'b1; press_ready = 1'b0;
        repeat (2) step();
        chk("rst_level", 32'(btn_level), 0);
        chk("rst_valid", 32'(press_valid), 0);
        chk("rst_code", 32'(press_code), 0);
        chk("rst_multi", 32'(multi_err), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        nm = 0; nv = 0;
        repeat (10) begin step(); nm += int'(multi_err); nv += int'(press_valid); end
        chk("rst_chord_level", 32'(btn_level), 32'hF);
        chk("rst_chord_multi", nm, 1);
        chk("rst_chord_valid", nv, 0);
        btn_raw = '0;
        repeat (8) step();

        // single press of button 2, exact latency, release, then consume
        btn_raw = 4'b0100;
        for (int j = 1; j <= 8; j++) begin
            step();
            if (j == 3) btn_raw = '0;
            if (j == 4) chk("single_level_early", 32'(btn_level[2]), 0);
            if (j == 5) begin
                chk("single_level_rise", 32'(btn_level[2]), 1);
                chk("single_valid_early", 32'(press_valid), 0);
            end
            if (j == 6) begin
                chk("single_valid", 32'(press_valid), 1);
                chk("single_code", 32'(press_code), 2);
            end
            if (j == 7) chk("single_level_hold", 32'(btn_level[2]), 1);
            if (j == 8) begin
                chk("single_level_fall", 32'(btn_level[2]), 0);
                chk("single_valid_held", 32'(press_valid), 1);
            end
        end
        press_ready = 1'b1;
        step();
        press_ready = 1'b0;
        chk("single_consumed", 32'(press_valid), 0);

        // two-sample glitch on button 0
        btn_raw = 4'b0001;
        step(); step();
        btn_raw = '0;
        nl = 0; nv = 0; nm = 0;
        repeat (8) begin
            step();
            nl += int'(btn_level != '0); nv += int'(press_valid); nm += int'(multi_err);
        end
        chk("glitch_level", nl, 0);
        chk("glitch_valid", nv, 0);
        chk("glitch_multi", nm, 0);

        // simultaneous chord, then a late third button while the chord is held
        btn_raw = 4'b1010;
        nm = 0; nv = 0;
        repeat (8) begin step(); nm += int'(multi_err); nv += int'(press_valid); end
        chk("chord_level", 32'(btn_level), 32'hA);
        chk("chord_multi", nm, 1);
        chk("chord_valid", nv, 0);
        btn_raw = 4'b1011;
        nm = 0; nv = 0;
        repeat (8) begin step(); nm += int'(multi_err); nv += int'(press_valid); end
        chk("late_chord_multi", nm, 1);
        chk("late_chord_valid", nv, 0);
        btn_raw = '0;
        repeat (8) step();

        // back-pressure: green then blue with no consumer
        press_btn(0, 0, n_ovf, n_multi, n_idle);
        chk("bp_green_valid", 32'(press_valid), 1);
        chk("bp_green_code", 32'(press_code), 0);
        chk("bp_green_ovf", n_ovf, 0);
        press_btn(2, 0, n_ovf, n_multi, n_idle);
        chk("bp_blue_ovf", n_ovf, 1);
        chk("bp_blue_code", 32'(press_code), 0);
        chk("bp_blue_idle", n_idle, 0);
        // consume lands on the same edge blue is accepted
        press_btn(2, 5, n_ovf, n_multi, n_idle);
        chk("bp_swap_code", 32'(press_code), 2);
        chk("bp_swap_valid", 32'(press_valid), 1);
        chk("bp_swap_idle", n_idle, 0);
        chk("bp_swap_ovf", n_ovf, 0);

        // enable gating
        press_ready = 1'b1;
        step();
        press_ready = 1'b0;
        chk("en_drain", 32'(press_valid), 0);
        press_btn(3, 0, n_ovf, n_multi, n_idle);
        chk("en_load_code", 32'(press_code), 3);
        enable = 1'b0;
        step();
        chk("en_off_valid", 32'(press_valid), 0);
        chk("en_off_code", 32'(press_code), 3);
        press_btn(1, 0, n_ovf, n_multi, n_idle);
        chk("en_off_idle", n_idle, 10);
        chk("en_off_multi", n_multi, 0);
        chk("en_off_level", 32'(btn_level), 0);
        enable = 1'b1;
        step();
        press_btn(1, 0, n_ovf, n_multi, n_idle);
        chk("en_on_valid", 32'(press_valid), 1);
        chk("en_on_code", 32'(press_code), 1);
        chk("en_on_multi", n_multi, 0);

        // random activity, including an asynchronous reset mid-stream
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < NB; b++) if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
            press_ready = ($urandom_range(0, 3) == 0);
            enable      = ($urandom_range(0, 19) != 0);
            if (c == 400) begin
                #3 rst_n = 1'b0;
                #1;
                chk("async_rst_valid", 32'(press_valid), 0);
                chk("async_rst_level", 32'(btn_level), 0);
                chk("async_rst_code", 32'(press_code), 0);
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
